// File: rtl/ex_wb_pkg.sv
// Shared widths, select encoding, FSM states and the held-result entry type
// for the execute-to-writeback skid stage.
package ex_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  localparam logic [2:0] SEL_NONE = 3'b111;

  // Field widths follow the package defaults; retarget them here, not per instance.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [RD_W_DEF-1:0]   rd;
    logic                  we;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ex_wb_skid_stage.sv
// Two-entry skid buffer between execute and writeback with a registered in_ready.
// Optional illegal-select checking is built when EXWB_SEL_CHECK_EN is defined.
module ex_wb_skid_stage
  import ex_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_sel,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we
`ifdef EXWB_SEL_CHECK_EN
  ,
  output logic              sel_err
`endif
);

  state_t state_q, state_d;
  logic   inReady_q;
  entry_t mainEntry_q, mainEntry_d;
  entry_t skidEntry_q, skidEntry_d;
  entry_t newEntry;
  logic   accept;
  logic   drain;

  assign accept = in_valid && inReady_q;
  assign drain  = out_valid && out_ready;

  // Writes to x0 are architecturally void, so the enable is dropped at capture.
  always_comb begin
    newEntry.result = in_result;
    newEntry.rd     = in_rd;
    newEntry.we     = in_we && (in_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      inReady_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !drain) state_d = FULL;
          else if (!accept && drain) state_d = EMPTY;
        end
        FULL:    if (drain) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid  = (state_q != EMPTY);
    in_ready   = inReady_q;
    out_result = mainEntry_q.result;
    out_rd     = mainEntry_q.rd;
    out_we     = mainEntry_q.we;
  end

  // A flushed cycle leaves the data registers untouched; only valid state is cleared.
  always_comb begin
    mainEntry_d = mainEntry_q;
    skidEntry_d = skidEntry_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (accept) mainEntry_d = newEntry;
        ONE: begin
          if (accept && drain) mainEntry_d = newEntry;
          else if (accept)     skidEntry_d = newEntry;
        end
        FULL:    if (drain) mainEntry_d = skidEntry_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainEntry_q <= '0;
      skidEntry_q <= '0;
    end else begin
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
    end
  end

`ifdef EXWB_SEL_CHECK_EN
  logic selErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selErr_q <= 1'b0;
    end else if (accept && (in_sel == SEL_NONE)) begin
      selErr_q <= 1'b1;
    end
  end

  assign sel_err = selErr_q;
`else
  logic unusedSel;
  assign unusedSel = ^in_sel;
`endif

endmodule

// File: tb/tb_ex_wb_skid_stage.sv
// Self-checking bench for ex_wb_skid_stage: directed scenarios plus a random
// run against a queue model. Define EXWB_SEL_CHECK_EN to cover sel_err.
module tb_ex_wb_skid_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          we;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_result;
  logic [2:0]    in_sel;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_we;
`ifdef EXWB_SEL_CHECK_EN
  logic          sel_err;
`endif

  int testsRun;
  int testsFailed;

  ex_wb_skid_stage #(.DATA_W(DW), .RD_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_sel    (in_sel),
    .in_rd     (in_rd),
    .in_we     (in_we),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_rd    (out_rd),
    .out_we    (out_we)
`ifdef EXWB_SEL_CHECK_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven and outputs read.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] r, input logic [RW-1:0] rd, input logic we);
    in_valid  = 1'b1;
    in_result = r;
    in_rd     = rd;
    in_we     = we;
    in_sel    = 3'd0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_sel    = 3'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_result = '0; in_rd = '0; in_we = 1'b0; in_sel = 3'd0;
    tick();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); end
    testsRun++; if (out_result !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_result: got %h, expected 0", out_result); end
    testsRun++; if (out_rd !== '0 || out_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_rd_we: got %h/%b, expected 0/0", out_rd, out_we); end
    rst_n = 1'b1;
    #1;
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_before_edge: got %b, expected 0", in_ready); end
    tick();
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ready_after_edge: got %b, expected 1", in_ready); end
    offer(32'h5555_0001, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL preload_valid: got %b, expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== '0) begin
      testsFailed++; $display("[TB] FAIL async_reset: got valid=%b ready=%b result=%h, expected 0/0/0", out_valid, in_ready, out_result);
    end
    tick();
    rst_n = 1'b1;
    tick();
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL post_reset: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    offer(32'hDEAD_BEEF, 5'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_valid: got %b, expected 1", out_valid); end
    testsRun++; if (out_result !== 32'hDEAD_BEEF || out_rd !== 5'd5 || out_we !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL single_data: got %h/%0d/%b, expected deadbeef/5/1", out_result, out_rd, out_we);
    end
    tick();
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL single_drained: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    offer(32'hAAAA_0000, 5'd1, 1'b1);
    tick();
    offer(32'hBBBB_0000, 5'd2, 1'b1);
    tick();
    offer(32'hCCCC_0000, 5'd3, 1'b1);
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_full_ready: got %b, expected 0", in_ready); end
    tick();
    testsRun++; if (out_result !== 32'hAAAA_0000) begin testsFailed++; $display("[TB] FAIL b2b_hold_A: got %h, expected aaaa0000", out_result); end
    out_ready = 1'b1;
    tick();
    testsRun++; if (out_valid !== 1'b1 || out_result !== 32'hBBBB_0000 || out_rd !== 5'd2) begin
      testsFailed++; $display("[TB] FAIL b2b_B: got %b/%h/%0d, expected 1/bbbb0000/2", out_valid, out_result, out_rd);
    end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_ready_back: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1 || out_result !== 32'hCCCC_0000 || out_rd !== 5'd3) begin
      testsFailed++; $display("[TB] FAIL b2b_C: got %b/%h/%0d, expected 1/cccc0000/3", out_valid, out_result, out_rd);
    end
    tick();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_empty: got %b, expected 0", out_valid); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    out_ready = 1'b1;
    offer(32'h0000_1234, 5'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_result !== 32'h0000_1234) begin
      testsFailed++; $display("[TB] FAIL rd_zero: got valid=%b we=%b result=%h, expected 1/0/00001234", out_valid, out_we, out_result);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    offer(32'hEEEE_0001, 5'd1, 1'b1);
    tick();
    offer(32'hEEEE_0002, 5'd2, 1'b1);
    tick();
    offer(32'hDDDD_0000, 5'd4, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL flush_full: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_no_D: got %b, expected 0", out_valid); end
    end
    out_ready = 1'b0;
    offer(32'hEEEE_0003, 5'd3, 1'b1);
    tick();
    offer(32'hDDDD_0001, 5'd5, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_one: got %b, expected 0", out_valid); end
    tick();
    testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL flush_accept_dropped: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

`ifdef EXWB_SEL_CHECK_EN
  task automatic test_sel_err();
    do_reset();
    testsRun++; if (sel_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL sel_err_reset: got %b, expected 0", sel_err); end
    out_ready = 1'b1;
    offer(32'hAAAA_5E1E, 5'd2, 1'b1);
    in_sel = 3'b111;
    tick();
    in_sel = 3'd0;
    testsRun++; if (sel_err !== 1'b1 || out_result !== 32'hAAAA_5E1E) begin
      testsFailed++; $display("[TB] FAIL sel_err_set: got %b/%h, expected 1/aaaa5e1e", sel_err, out_result);
    end
    for (int i = 0; i < 3; i++) begin
      offer(32'(i), 5'd7, 1'b1);
      tick();
      testsRun++; if (sel_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL sel_err_sticky: got %b, expected 1", sel_err); end
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    testsRun++; if (sel_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL sel_err_clear: got %b, expected 0", sel_err); end
    do_reset();
  endtask
`endif

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic modelReady;
    logic expValid;
    logic acc;
    logic drn;
    logic flushNow;
    do_reset();
    modelReady = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      flushNow  = ($urandom_range(0, 63) == 0);
      flush     = flushNow;
      in_result = $urandom();
      in_rd     = RW'($urandom_range(0, 31));
      in_we     = ($urandom_range(0, 1) == 1);
      in_sel    = 3'($urandom_range(0, 6));
      #1;
      expValid = (q.size() > 0);
      testsRun++; if (in_ready !== modelReady) begin
        testsFailed++; $display("[TB] FAIL rand_ready cycle %0d: got %b, expected %b", c, in_ready, modelReady);
      end
      testsRun++; if (out_valid !== expValid) begin
        testsFailed++; $display("[TB] FAIL rand_valid cycle %0d: got %b, expected %b", c, out_valid, expValid);
      end
      if (expValid) begin
        testsRun++; if ({out_result, out_rd, out_we} !== q[0]) begin
          testsFailed++; $display("[TB] FAIL rand_data cycle %0d: got %h/%0d/%b, expected %h/%0d/%b",
                                  c, out_result, out_rd, out_we, q[0].result, q[0].rd, q[0].we);
        end
      end
      out_ready = ~out_ready;
      #1;
      testsRun++; if (in_ready !== modelReady) begin
        testsFailed++; $display("[TB] FAIL rand_ready_indep cycle %0d: got %b, expected %b", c, in_ready, modelReady);
      end
      out_ready = ~out_ready;
      acc = in_valid && modelReady;
      drn = expValid && out_ready;
      e   = '{result: in_result, rd: in_rd, we: in_we && (in_rd != '0)};
      tick();
      if (flushNow) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      modelReady = (q.size() < 2);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rd_zero();
    test_flush();
`ifdef EXWB_SEL_CHECK_EN
    test_sel_err();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ex_wb_skid_stage.md
EX_WB_SKID_STAGE -- requirements
Module: ex_wb_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the execute result word.
REQ-002 Parameter RD_W, default 5, width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  execute stage presents a result this cycle.
REQ-006 in_ready  output  1  stage accepts the presented result this cycle.
REQ-007 in_result  input  DATA_W  selected execute result from the 8:1 result mux.
REQ-008 in_sel  input  3  result-mux select that produced in_result; 3'b111 means no unit selected (zero result).
REQ-009 in_rd  input  RD_W  destination register index.
REQ-010 in_we  input  1  register write enable.
REQ-011 flush  input  1  discard all held results (branch mispredict / exception).
REQ-012 out_valid  output  1  writeback result valid.
REQ-013 out_ready  input  1  writeback consumes the result this cycle.
REQ-014 out_result  output  DATA_W  registered result.
REQ-015 out_rd  output  RD_W  registered destination index.
REQ-016 out_we  output  1  registered write enable.
REQ-017 sel_err  output  1  sticky illegal-select flag (present only with EXWB_SEL_CHECK_EN).

Function
REQ-018 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-019 Storage: one output register (main) plus one skid register; capacity 2 results, in-order.
REQ-020 Latency: an accepted result appears on out_* the next cycle when main is empty or drains in the accept cycle.
REQ-021 in_ready is a register output, equal to NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-022 States: EMPTY (main and skid invalid), ONE (main valid), FULL (main and skid valid).
REQ-023 EMPTY: accept -> ONE.
REQ-024 ONE: accept without drain -> FULL (result to skid); accept with drain -> ONE (new result to main); drain only -> EMPTY.
REQ-025 FULL: in_ready=0; drain -> ONE, skid moves to main same edge.
REQ-026 Ordering: out_* always presents the oldest held result; no reorder, duplication or loss.
REQ-027 Accepted in_rd==0 stores we=0 regardless of in_we; result stored unchanged.
REQ-028 flush: next edge clears main and skid valid bits; any same-cycle accept is discarded; state -> EMPTY; out_valid=0 next cycle.
REQ-029 Data registers load only on accept or skid-to-main move; otherwise they hold value.
REQ-030 out_* data is stable while out_valid && !out_ready.

Reset
REQ-031 rst_n low asynchronously forces out_valid=0, skid_valid=0, in_ready=0, out_result=0, out_rd=0, out_we=0, sel_err=0.
REQ-032 in_ready rises to 1 on the first clk edge after rst_n deasserts.
REQ-033 Reset mid-operation discards all held results; no partial transfer is reported.

Configuration
REQ-034 Macro EXWB_SEL_CHECK_EN defined: an accept with in_sel==3'b111 sets sel_err, which stays 1 until reset; the result is still stored and forwarded.
REQ-035 Macro EXWB_SEL_CHECK_EN undefined: in_sel is ignored, sel_err is not present, and no check logic is built.

Structure
REQ-036 Shared package ex_wb_pkg holds the DATA_W and RD_W defaults, SEL_NONE=3'b111, and the typedef for the packed result entry {result, rd, we}.
REQ-037 No sub-module; main and skid registers are built as two instances of the package entry type inside one module.

Verification
REQ-038 Reset then single accept of result 32'hDEAD_BEEF, rd=5, we=1, with out_ready=1 -> out_valid=1 the next cycle with the same data; EMPTY again after the drain.
REQ-039 out_ready=0 with three back-to-back offers A, B, C -> A and B accepted, in_ready=0 on the third cycle; after out_ready=1, outputs appear in order A, B, then C.
REQ-040 Accept rd=0, in_we=1, result 32'h1234 -> out_we=0 and out_result=32'h1234.
REQ-041 FULL plus flush=1 with in_valid=1 offering D -> next cycle out_valid=0 and in_ready=1; D never appears on out_*.
REQ-042 Macro EXWB_SEL_CHECK_EN defined, accept with in_sel=3'b111 -> sel_err=1 the next cycle and held through later legal traffic; rst_n low clears it.
REQ-043 Random in_valid/out_ready at 50% over 10k cycles, scoreboard check -> no loss, duplication or reorder; in_ready never depends on same-cycle out_ready.
